// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues a single-beat read at the current PC and latches the returned word.
// Optional FETCH_TIMEOUT_EN bounds the time spent waiting for the memory response.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FetchStart,
    input  logic [ADDR_WIDTH-1:0] CurrentInstruction,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemRespValid,
    input  logic [DATA_WIDTH-1:0] MemRespData,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic [ADDR_WIDTH-1:0] NextSeqAddr,
    output logic                  FetchBusy,
    output logic                  FetchError
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] next_seq_q, next_seq_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // cnt_q counts completed WAIT cycles, so the limit is hit in the last allowed one
    logic limit_hit;
    assign limit_hit = (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        next_seq_d = next_seq_q;
        instr_d    = instr_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (FetchStart) begin
                    if (CurrentInstruction[1:0] == 2'b00) begin
                        mem_addr_d = CurrentInstruction;
                        next_seq_d = CurrentInstruction + ADDR_WIDTH'(4);
                        state_d    = StReq;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StReq: begin
                if (MemReqReady) begin
                    state_d = StWait;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StWait: begin
                if (MemRespValid) begin
                    instr_d = MemRespData;
                    state_d = StDone;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (limit_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
`endif
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            next_seq_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            next_seq_q <= next_seq_d;
            instr_q    <= instr_d;
        end
    end

    assign MemReqValid = (state_q == StReq);
    assign MemAddr     = mem_addr_q;
    assign Instruction = instr_q;
    assign NextSeqAddr = next_seq_q;
    assign InstrValid  = (state_q == StDone);
    assign FetchError  = (state_q == StErr);
    assign FetchBusy   = (state_q != StIdle);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed corner cases plus randomized fetches.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] cur_instr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] mem_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] next_seq;
    logic        busy;
    logic        fetch_error;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        is_err;
        logic [31:0] instr;
        logic [31:0] nsa;
    } exp_t;

    exp_t exp_q[$];

    // Architectural view of the unit: last fetched word and last captured PC + 4
    logic [31:0] model_instr;
    logic [31:0] model_nsa;

    instr_fetch_unit #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK               (clk),
        .RST               (rst),
        .FetchStart        (fetch_start),
        .CurrentInstruction(cur_instr),
        .MemReqValid       (req_valid),
        .MemReqReady       (req_ready),
        .MemAddr           (mem_addr),
        .MemRespValid      (resp_valid),
        .MemRespData       (resp_data),
        .Instruction       (instruction),
        .InstrValid        (instr_valid),
        .NextSeqAddr       (next_seq),
        .FetchBusy         (busy),
        .FetchError        (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (instr_valid || fetch_error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", {instr_valid, fetch_error}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("completion_is_error", fetch_error, e.is_err);
                check("completion_one_kind", instr_valid & fetch_error, 1'b0);
                check("instruction", instruction, e.instr);
                check("next_seq_addr", next_seq, e.nsa);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in an idle cycle, 1 time unit after the edge; returns in the first idle cycle after.
    task automatic do_fetch(input logic [31:0] pc, input int rdly, input int wdly,
                            input logic [31:0] data);
        exp_t e;
        if (pc[1:0] != 2'b00) begin
            e.is_err = 1'b1;
        end else begin
            e.is_err    = 1'b0;
            model_instr = data;
            model_nsa   = pc + 32'd4;
        end
        e.instr = model_instr;
        e.nsa   = model_nsa;
        exp_q.push_back(e);

        fetch_start = 1'b1;
        cur_instr   = pc;
        tick();
        fetch_start = 1'b0;
        cur_instr   = $urandom;

        if (pc[1:0] != 2'b00) begin
            resp_valid = 1'b1;
            resp_data  = $urandom;
            @(negedge clk);
            check("misaligned_no_req", req_valid, 1'b0);
            check("misaligned_error_pulse", fetch_error, 1'b1);
            tick();
            resp_valid = 1'b0;
            @(negedge clk);
            check("error_one_cycle", fetch_error, 1'b0);
            check("idle_after_error", busy, 1'b0);
            tick();
            return;
        end

        for (int i = 0; i < rdly; i++) begin
            resp_valid = 1'($urandom_range(0, 1));
            resp_data  = $urandom;
            @(negedge clk);
            check("req_valid_held", req_valid, 1'b1);
            check("mem_addr_stable", mem_addr, pc);
            tick();
        end
        req_ready  = 1'b1;
        resp_valid = 1'($urandom_range(0, 1));
        resp_data  = $urandom;
        @(negedge clk);
        check("req_valid_at_accept", req_valid, 1'b1);
        check("mem_addr_at_accept", mem_addr, pc);
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        for (int j = 0; j < wdly; j++) begin
            fetch_start = 1'($urandom_range(0, 1));
            cur_instr   = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            check("no_req_in_wait", req_valid, 1'b0);
            tick();
        end
        fetch_start = 1'b0;
        resp_valid  = 1'b1;
        resp_data   = data;
        @(negedge clk);
        check("no_req_at_resp", req_valid, 1'b0);
        tick();
        resp_valid = 1'b0;
        resp_data  = $urandom;
        @(negedge clk);
        check("instr_valid_latency", instr_valid, 1'b1);
        tick();
    endtask

    task automatic reset_pulse;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_instr = '0;
        model_nsa   = '0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        rst         = 1'b1;
        fetch_start = 1'b0;
        cur_instr   = '0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        model_instr = '0;
        model_nsa   = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_req_valid", req_valid, 1'b0);
        check("reset_instruction", instruction, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_next_seq", next_seq, 32'h0);
        check("reset_pulses", {instr_valid, fetch_error}, 2'b00);
        tick();
        rst = 1'b0;
        tick();

        // Directed: zero-wait fetch, back-to-back, backpressure, wrap, misalignment
        do_fetch(32'h0000_0010, 0, 0, 32'h00A0_0093);
        do_fetch(32'h0000_0014, 0, 2, 32'h1234_5678);
        do_fetch(32'h0000_0100, 5, 3, 32'hCAFE_F00D);
        do_fetch(32'hFFFF_FFFC, 1, 0, 32'h0000_0013);
        do_fetch(32'h0000_0006, 0, 0, 32'h0);
        do_fetch(32'h0000_0200, 0, 0, 32'h5555_AAAA);

        // Reset mid-WAIT; the stale response afterwards must not land
        fetch_start = 1'b1;
        cur_instr   = 32'h0000_0300;
        tick();
        fetch_start = 1'b0;
        req_ready   = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        rst = 1'b1;
        model_instr = '0;
        model_nsa   = '0;
        @(negedge clk);
        check("midwait_reset_busy", busy, 1'b0);
        check("midwait_reset_instruction", instruction, 32'h0);
        check("midwait_reset_req_valid", req_valid, 1'b0);
        check("midwait_reset_next_seq", next_seq, 32'h0);
        tick();
        rst        = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        check("stale_resp_instruction", instruction, 32'h0);
        check("stale_resp_busy", busy, 1'b0);
        tick();

        for (int k = 0; k < 40; k++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            do_fetch(pc, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), $urandom);
        end

        // No response at all
        fetch_start = 1'b1;
        cur_instr   = 32'h0000_0400;
        tick();
        fetch_start = 1'b0;
        req_ready   = 1'b1;
        tick();
        req_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        begin
            exp_t e;
            model_nsa = 32'h0000_0404;
            e.is_err  = 1'b1;
            e.instr   = model_instr;
            e.nsa     = model_nsa;
            exp_q.push_back(e);
        end
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            check("timeout_wait_busy", busy, 1'b1);
            check("timeout_no_early_error", fetch_error, 1'b0);
            tick();
        end
        @(negedge clk);
        check("timeout_error_pulse", fetch_error, 1'b1);
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("timeout_error_one_cycle", fetch_error, 1'b0);
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp_ignored", instruction, model_instr);
        check("late_resp_idle", busy, 1'b0);
        tick();
`else
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            check("no_timeout_busy", busy, 1'b1);
            check("no_timeout_error", fetch_error, 1'b0);
            tick();
        end
        reset_pulse();
`endif

        do_fetch(32'h0000_0500, 2, 1, 32'h0BAD_C0DE);
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
